if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_fetch.sv | 112 +++++++++++
 tb/tb_if_fetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Imported by if_fetch; holds bus widths, control levels and IF states.
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned STALL_W     = 6;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;

    localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

    // FETCH: request outstanding; READY: word held; KILL: outstanding request to discard
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_READY = 2'd1,
        ST_KILL  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding instruction-bus read at a time,
// with delay-slot branch recording and flush-kill of in-flight reads.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    output logic                   ibus_req,
    output logic [INST_ADDR_W-1:0] ibus_addr,
    input  logic                   ibus_ack,
    input  logic [INST_W-1:0]      ibus_rdata,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   stallreq_if
);

    if_state_e              state;
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_ADDR_W-1:0] req_addr;
    logic                   br_pend;
    logic [INST_ADDR_W-1:0] br_tgt;
    logic [INST_ADDR_W-1:0] next_pc;
    logic                   unused_stall;

    // Only bit 0 of the stall vector concerns this stage.
    assign unused_stall = ^stall[STALL_W-1:1];

    // A recorded delay-slot branch wins over a branch resolving in the consume cycle.
    assign next_pc = br_pend     ? br_tgt :
                     branch_flag ? branch_target :
                     pc + INST_ADDR_W'(4);

    // Request decoded from the state register, forced low by reset without waiting for a clock.
    assign ibus_req    = (rst != RST_ENABLE) && (state != ST_READY);
    assign stallreq_if = (rst != RST_ENABLE) && (state != ST_READY);
    assign ibus_addr   = req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state    <= ST_FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            br_pend  <= 1'b0;
            br_tgt   <= ZERO_WORD;
            if_pc    <= ZERO_WORD;
            if_inst  <= ZERO_WORD;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (flush) begin
                        pc      <= new_pc;
                        if_pc   <= ZERO_WORD;
                        if_inst <= ZERO_WORD;
                        br_pend <= 1'b0;
                        if (ibus_ack) begin
                            req_addr <= new_pc;
                        end else begin
                            state <= ST_KILL;
                        end
                    end else begin
                        if (branch_flag) begin
                            br_pend <= 1'b1;
                            br_tgt  <= branch_target;
                        end
                        if (ibus_ack) begin
                            if_inst <= ibus_rdata;
                            if_pc   <= req_addr;
                            state   <= ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (flush) begin
                        pc       <= new_pc;
                        req_addr <= new_pc;
                        if_pc    <= ZERO_WORD;
                        if_inst  <= ZERO_WORD;
                        br_pend  <= 1'b0;
                        state    <= ST_FETCH;
                    end else if (stall[0] == NO_STOP) begin
                        pc       <= next_pc;
                        req_addr <= next_pc;
                        br_pend  <= 1'b0;
                        state    <= ST_FETCH;
                    end
                end
                ST_KILL: begin
                    // The outstanding read keeps its address; its data is dropped on ack.
                    if (flush) begin
                        pc <= new_pc;
                    end else if (branch_flag) begin
                        br_pend <= 1'b1;
                        br_tgt  <= branch_target;
                    end
                    if (ibus_ack) begin
                        req_addr <= flush ? new_pc : pc;
                        state    <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// stall/flush/branch/ack traffic against a transaction-level reference model.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: outstanding read, whether its data is unwanted, architectural PC
    bit          m_busy;
    bit          m_discard;
    bit          m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_tgt;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_inst;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack),
        .ibus_rdata(ibus_rdata), .if_pc(if_pc), .if_inst(if_inst),
        .stallreq_if(stallreq_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b1;
        m_discard = 1'b0;
        m_pend    = 1'b0;
        m_pc      = RST_PC;
        m_addr    = RST_PC;
        m_tgt     = 32'h0;
        m_if_pc   = 32'h0;
        m_if_inst = 32'h0;
    endtask

    task automatic check_outputs();
        check("ibus_req", 32'(ibus_req), 32'(m_busy));
        check("stallreq_if", 32'(stallreq_if), 32'(m_busy));
        check("if_pc", if_pc, m_if_pc);
        check("if_inst", if_inst, m_if_inst);
        if (m_busy) check("ibus_addr", ibus_addr, m_addr);
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input logic [5:0] s, input logic f, input logic [31:0] np,
                        input logic b, input logic [31:0] bt,
                        input logic a, input logic [31:0] rd);
        logic [31:0] nxt;
        stall = s; flush = f; new_pc = np; branch_flag = b;
        branch_target = bt; ibus_ack = a; ibus_rdata = rd;
        if (m_busy) begin
            if (f) begin
                m_pc = np;
                if (!m_discard) begin
                    m_if_pc = 32'h0; m_if_inst = 32'h0; m_pend = 1'b0;
                end
                if (a) begin
                    m_discard = 1'b0; m_addr = np;
                end else begin
                    m_discard = 1'b1;
                end
            end else begin
                if (b) begin
                    m_pend = 1'b1; m_tgt = bt;
                end
                if (a && m_discard) begin
                    m_discard = 1'b0; m_addr = m_pc;
                end else if (a) begin
                    m_if_pc = m_addr; m_if_inst = rd; m_busy = 1'b0;
                end
            end
        end else if (f) begin
            m_pc = np; m_addr = np; m_if_pc = 32'h0; m_if_inst = 32'h0;
            m_pend = 1'b0; m_busy = 1'b1;
        end else if (!s[0]) begin
            nxt = m_pend ? m_tgt : (b ? bt : m_pc + 32'd4);
            m_pc = nxt; m_addr = nxt; m_pend = 1'b0; m_busy = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic a);
        step(6'h00, 1'b0, 32'h0, 1'b0, 32'h0, a, $urandom);
    endtask

    initial begin
        logic [5:0]  rs;
        logic [31:0] rnp;
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; branch_flag = 1'b0;
        branch_target = '0; ibus_ack = 1'b0; ibus_rdata = '0;
        repeat (2) @(negedge clk);
        check("reset_req", 32'(ibus_req), 32'h0);
        check("reset_stallreq", 32'(stallreq_if), 32'h0);
        check("reset_if_pc", if_pc, 32'h0);
        check("reset_if_inst", if_inst, 32'h0);
        rst = 1'b0;
        model_reset();
        #1;
        check("first_req", 32'(ibus_req), 32'h1);
        check("first_addr", ibus_addr, RST_PC);
        check_outputs();

        // Sequential fetch, ack one cycle after request
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            idle(1'b1);
            check("seq_if_pc", if_pc, RST_PC + 32'(4 * i));
            idle(1'b0);
        end

        // Stall hold in READY
        idle(1'b1);
        for (int i = 0; i < 5; i++) step(6'h01, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("hold_if_pc", if_pc, RST_PC + 32'h0C);
        check("hold_req", 32'(ibus_req), 32'h0);
        idle(1'b0);
        check("after_hold_addr", ibus_addr, RST_PC + 32'h10);

        // Branch recorded during the delay-slot fetch
        step(6'h00, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0, 32'h0);
        idle(1'b1);
        check("slot_if_pc", if_pc, RST_PC + 32'h10);
        idle(1'b0);
        check("branch_addr", ibus_addr, 32'h8000_0100);

        // Flush with a request outstanding, ack three cycles later
        step(6'h00, 1'b1, 32'hBFC0_0380, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0);
        idle(1'b0);
        check("kill_addr_held", ibus_addr, 32'h8000_0100);
        step(6'h00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        check("kill_if_inst", if_inst, 32'h0);
        check("redirect_addr", ibus_addr, 32'hBFC0_0380);

        // PC wrap at the top of the address space
        step(6'h00, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        idle(1'b1);
        idle(1'b0);
        check("wrap_addr", ibus_addr, 32'h0000_0000);

        // Asynchronous reset in the middle of a fetch
        #2 rst = 1'b1; ibus_ack = 1'b1;
        #1;
        check("async_req", 32'(ibus_req), 32'h0);
        check("async_stallreq", 32'(stallreq_if), 32'h0);
        @(negedge clk);
        ibus_ack = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        check("rerst_addr", ibus_addr, RST_PC);
        check_outputs();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(2) == 0) ? 6'($urandom) : 6'h00;
            rnp = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step(rs, $urandom_range(11) == 0, rnp, $urandom_range(3) == 0, $urandom,
                 $urandom_range(2) == 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
